student_mult_seq: RTL and testbench

Multi-cycle 16-bit multiplier sequencer built around the existing `student_alu`. An FSM drives the ALU's six control bits to run shift-and-add multiplication and reuses the ALU adder for both accumulation and doubling. The product is the low 16 bits (two's-complement correct modulo 2^16). It sits beside the CPU datapath as the project's first multi-cycle arithmetic unit, with a start/busy/done handshake.

---
 rtl/student_mult_seq_pkg.sv | 14 +
 rtl/student_mult_seq_if.sv | 22 ++
 rtl/student_alu.sv | 28 ++
 rtl/student_reg16.sv | 15 +
 rtl/student_mult_seq.sv | 108 ++++++++++
 tb/tb_student_mult_seq.sv | 173 +++++++++++++++++
 6 files changed

// File: rtl/student_mult_seq_pkg.sv
// Shared constants for the shift-and-add multiplier: ALU control words
// and FSM state encodings.
package student_mult_seq_pkg;

   // Control word bit order: zx,nx,zy,ny,f,no
   localparam logic [5:0] ALU_X_PLUS_Y = 6'b000010;
   localparam logic [5:0] ALU_X        = 6'b001010;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADD  = 2'd1;
   localparam logic [1:0] DBL  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

endpackage

// File: rtl/student_mult_seq_if.sv
// start/busy/done handshake and operand/result bus of the multiplier.
// master drives the request, slave is the multiplier.
interface student_mult_seq_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        zr;
   logic        ng;

   modport master (
      output start, a, b,
      input  busy, done, product, zr, ng
   );

   modport slave (
      input  start, a, b,
      output busy, done, product, zr, ng
   );
endinterface

// File: rtl/student_alu.sv
// 16-bit six-control-bit ALU (zx,nx,zy,ny,f,no), purely combinational.
module student_alu (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);
   logic [15:0] x1, x2, y1, y2, fo;

   always_comb begin
      x1  = zx ? 16'h0000 : x;
      x2  = nx ? ~x1 : x1;
      y1  = zy ? 16'h0000 : y;
      y2  = ny ? ~y1 : y1;
      fo  = f ? (x2 + y2) : (x2 & y2);
      out = no ? ~fo : fo;
   end

   assign zr = (out == 16'h0000);
   assign ng = out[15];
endmodule

// File: rtl/student_reg16.sv
// 16-bit register with load enable and synchronous active-high reset.
module student_reg16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] d,
   output logic [15:0] q
);
   always_ff @(posedge clk) begin
      if (reset)
         q <= 16'h0000;
      else if (load)
         q <= d;
   end
endmodule

// File: rtl/student_mult_seq.sv
// Multi-cycle 16x16 (low 16 bits) shift-and-add multiplier on student_alu.
// Define STUDENT_MULT_EARLY_EXIT_EN to stop once the multiplier runs out of ones.
module student_mult_seq (
   input  logic               clk,
   input  logic               reset,
   student_mult_seq_if.slave  bus
);
   import student_mult_seq_pkg::*;

   logic [1:0]  state, nextState;
   logic [3:0]  cnt;
   logic [15:0] acc, mcand, mplier, result;
   logic [15:0] aluX, aluOut;
   logic [5:0]  ctrl;
   logic [1:0]  unusedAluFlags;
   logic        accept, inAdd, inDbl, lastIter;

   assign accept = (state == IDLE) && bus.start;
   assign inAdd  = (state == ADD);
   assign inDbl  = (state == DBL);

`ifdef STUDENT_MULT_EARLY_EXIT_EN
   assign lastIter = (cnt == 4'd15) || (mplier[15:1] == 15'd0);
`else
   assign lastIter = (cnt == 4'd15);
`endif

   // ADD accumulates (or passes acc through), DBL doubles mcand via x+x
   assign aluX = inDbl ? mcand : acc;
   assign ctrl = (inAdd && !mplier[0]) ? ALU_X : ALU_X_PLUS_Y;

   student_alu alu (
      .x   (aluX),
      .y   (mcand),
      .zx  (ctrl[5]),
      .nx  (ctrl[4]),
      .zy  (ctrl[3]),
      .ny  (ctrl[2]),
      .f   (ctrl[1]),
      .no  (ctrl[0]),
      .out (aluOut),
      .zr  (unusedAluFlags[0]),
      .ng  (unusedAluFlags[1])
   );

   student_reg16 accReg (
      .clk   (clk),
      .reset (reset),
      .load  (accept || inAdd),
      .d     (accept ? 16'h0000 : aluOut),
      .q     (acc)
   );

   student_reg16 mcandReg (
      .clk   (clk),
      .reset (reset),
      .load  (accept || inDbl),
      .d     (accept ? bus.a : aluOut),
      .q     (mcand)
   );

   student_reg16 mplierReg (
      .clk   (clk),
      .reset (reset),
      .load  (accept || inDbl),
      .d     (accept ? bus.b : {1'b0, mplier[15:1]}),
      .q     (mplier)
   );

   // Captured on the edge into DONE so product is valid alongside done
   student_reg16 resultReg (
      .clk   (clk),
      .reset (reset),
      .load  (inDbl && lastIter),
      .d     (acc),
      .q     (result)
   );

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE: if (bus.start) nextState = ADD;
         ADD:  nextState = DBL;
         DBL:  nextState = lastIter ? DONE : ADD;
         DONE: nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= nextState;
         if (accept)
            cnt <= 4'd0;
         else if (inDbl && !lastIter)
            cnt <= cnt + 4'd1;
      end
   end

   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
   assign bus.product = result;
   assign bus.zr      = (result == 16'h0000);
   assign bus.ng      = result[15];
endmodule

// File: tb/tb_student_mult_seq.sv
// Randomized and directed checks of student_mult_seq against an arithmetic model.
module tb_student_mult_seq;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   student_mult_seq_if bus ();

   student_mult_seq dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int expLat(input logic [15:0] m);
`ifdef STUDENT_MULT_EARLY_EXIT_EN
      int h;
      h = 0;
      for (int i = 0; i < 16; i++)
         if (m[i]) h = i;
      return 2 * (h + 1) + 1;
`else
      return 33;
`endif
   endfunction

   // stAt: cycle at which a stray start pulse is injected (-1: none)
   // rsAt: cycle during which reset is held high (-1: none)
   task automatic runOp(input logic [15:0] ta, input logic [15:0] tb,
                        input int stAt, input int rsAt);
      int          n;
      int          pulses;
      bit          busyOk;
      logic [15:0] expP;
      expP = 16'(32'(ta) * 32'(tb));
      @(negedge clk);
      bus.a = ta;
      bus.b = tb;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      n = 1;
      busyOk = 1'b1;
      while (!bus.done && n <= 40) begin
         if (!bus.busy) busyOk = 1'b0;
         if (n == stAt) begin
            bus.start = 1'b1;
            bus.a = 16'd1;
            bus.b = 16'd1;
         end else if (n == stAt + 1) begin
            bus.start = 1'b0;
         end
         if (n == rsAt) reset = 1'b1;
         @(posedge clk);
         #1;
         n++;
         if (rsAt > 0 && n == rsAt + 1) begin
            reset = 1'b0;
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_prod", 32'(bus.product), 32'd0);
            check("rst_zr", 32'(bus.zr), 32'd1);
            break;
         end
      end
      if (rsAt <= 0) begin
         check("latency", 32'(n), 32'(expLat(tb)));
         check("busy_run", 32'(busyOk), 32'd1);
         check("busy_done", 32'(bus.busy), 32'd1);
         check("product", 32'(bus.product), 32'(expP));
         check("zr", 32'(bus.zr), 32'(expP == 16'h0000));
         check("ng", 32'(bus.ng), 32'(expP[15]));
         @(posedge clk);
         #1;
         check("done_pulse", 32'(bus.done), 32'd0);
         check("busy_idle", 32'(bus.busy), 32'd0);
         check("prod_hold", 32'(bus.product), 32'(expP));
      end
      if (stAt > 0 || rsAt > 0) begin
         pulses = 0;
         repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
         end
         check("extra_done", 32'(pulses), 32'd0);
      end
   endtask

   initial begin
      int          q[$];
      int          lat;
      int          n;
      logic [15:0] ra, rb;
      total = 0;
      bad = 0;
      bus.start = 1'b0;
      bus.a = 16'h0000;
      bus.b = 16'h0000;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy0", 32'(bus.busy), 32'd0);
      check("rst_done0", 32'(bus.done), 32'd0);
      check("rst_prod0", 32'(bus.product), 32'd0);
      check("rst_zr0", 32'(bus.zr), 32'd1);
      check("rst_ng0", 32'(bus.ng), 32'd0);
      reset = 1'b0;

      runOp(16'd3, 16'd5, -1, -1);
      runOp(16'hFFFF, 16'h0002, -1, -1);
      runOp(16'd300, 16'd300, -1, -1);
      runOp(16'h1234, 16'h0000, -1, -1);
      runOp(16'h8000, 16'h0001, -1, -1);
      runOp(16'hFFFF, 16'hFFFF, -1, -1);
      runOp(16'd7, 16'd9, 10, -1);
      runOp(16'd7, 16'd9, -1, 10);

      for (int i = 0; i < 20; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom) >> $urandom_range(0, 15);
         runOp(ra, rb, -1, -1);
      end

      // start held high: back-to-back results
      lat = expLat(16'd3);
      @(negedge clk);
      bus.a = 16'd2;
      bus.b = 16'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      for (n = 1; n <= 105; n++) begin
         if (bus.done) begin
            q.push_back(n);
            check("b2b_prod", 32'(bus.product), 32'd6);
         end
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      check("b2b_count", 32'(q.size() >= 3), 32'd1);
      for (int k = 0; k < 3; k++)
         if (k < q.size())
            check("b2b_when", 32'(q[k]), 32'(lat + k * (lat + 1)));
      n = 0;
      while (bus.busy && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("b2b_drain", 32'(bus.busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
